mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port among N_CORES execute/mem pipeline stages, one transaction at a time.
- Arbitration is round-robin.
- Each core's execute/mem pipeline register is held by a per-core stall until that core's access completes.
- Sits between the cores' execute/mem pipe registers and the shared synchronous data memory.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 64, memory address width.
- DATA_W, 64, memory data width.
- RD_LAT, 2, read latency: cycles from the memory sampling mem_en_o to valid mem_rdata_i (1..7).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  N_CORES  per-core access request (the core's WMemEn or a load at the mem stage).
- we_i  in  N_CORES  per-core write (1) / read (0).
- addr_i  in  N_CORES*ADDR_W  per-core address; core i occupies bits [ADDR_W*i +: ADDR_W].
- wdata_i  in  N_CORES*DATA_W  per-core write data; core i occupies bits [DATA_W*i +: DATA_W].
- stall_o  out  N_CORES  combinational, req_i & ~done_o; drives the inverse of the pipe-register enable.
- done_o  out  N_CORES  registered one-cycle pulse: the granted core's access is complete.
- rdata_o  out  DATA_W  registered last read data; valid while done_o pulses for a read.
- mem_en_o  out  1  registered memory access strobe.
- mem_we_o  out  1  registered memory write enable.
- mem_addr_o  out  ADDR_W  registered memory address.
- mem_wdata_o  out  DATA_W  registered memory write data.
- mem_rdata_i  in  DATA_W  memory read data.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, ptr=0, cnt=0.
  - All registered outputs 0: done_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o.
  - Any in-flight transaction is discarded.
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE:
  - If req_i is nonzero, pick winner w as the first set bit searching from ptr upward, modulo N_CORES.
  - Register owner=w, ptr=(w+1) mod N_CORES.
  - Register mem_en_o=1, mem_we_o=we_i[w], mem_addr_o=addr slice w, mem_wdata_o=wdata slice w.
  - Go to ISSUE.
  - If req_i is zero, stay in IDLE with mem_en_o=0.
- ISSUE:
  - Lasts exactly one cycle with mem_en_o=1; the memory samples at the edge ending this cycle.
  - Next: mem_en_o=0, mem_we_o=0, mem_addr_o and mem_wdata_o hold their values.
  - Write → RESP. Read → RD_WAIT with cnt=1.
- RD_WAIT:
  - cnt increments each cycle.
  - When cnt==RD_LAT, capture rdata_o<=mem_rdata_i and go to RESP.
  - Occupies exactly RD_LAT cycles.
- RESP:
  - done_o[owner]=1 for exactly one cycle; all other done bits stay 0.
  - Next state IDLE.
  - The core must drop or replace its request at the edge ending RESP; the arbiter samples req_i again only in IDLE.
- Latency, request seen in IDLE at cycle 0:
  - Write: ISSUE in cycle 1, done in cycle 2.
  - Read: ISSUE in cycle 1, data valid in cycle 1+RD_LAT, done in cycle 2+RD_LAT.
- At most one outstanding transaction at any time.
- A grant never changes mid-transaction; req_i and we_i changes after grant are ignored.
- If the owner drops req_i after grant, the transaction still completes and done_o still pulses.
- rdata_o changes only on read capture; writes leave it unchanged.
- stall_o[i] is 1 for every requesting core except during its own done pulse.
- Simultaneous requests: only the winner proceeds; losers stay stalled and compete again in the next IDLE.
- ptr wraps from N_CORES-1 to 0.
- Starvation bound: a requesting core is granted within N_CORES-1 other transactions.

Test Plan:
- Write from core 0: req_i=0001, we_i=0001, addr=0x10, wdata=0xDEADBEEF in cycle 0 → cycle 1 mem_en_o=1, mem_we_o=1, mem_addr_o=0x10, mem_wdata_o=0xDEADBEEF; cycle 2 done_o=0001; stall_o[0]=1 in cycles 0-1 and 0 in cycle 2.
- Read from core 2, RD_LAT=2, mem_rdata_i=0x1234 in cycle 3 → cycle 1 mem_en_o=1, mem_we_o=0; cycle 4 done_o=0100 and rdata_o=0x1234; rdata_o holds 0x1234 after a later write.
- All four cores issue back-to-back writes starting at ptr=0 → grants in order 0,1,2,3,0; a done pulse every 3 cycles; ptr wraps to 0.
- Fairness: ptr=2 with req_i=1010 → core 3 granted first, then core 1; core 1 stall_o stays 1 until its own done pulse.
- Reset asserted mid RD_WAIT → all outputs 0 immediately, without waiting for a clock edge. After release with req_i=0010: grant to core 1, mem_en_o=1 one cycle later.
- Owner drops req_i during ISSUE → done_o pulse still occurs on schedule; no second ISSUE for that core.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets N_CORES execute/mem pipeline stages share one synchronous data-memory
// port. Only one transaction is in flight at a time, and grants rotate
// round-robin.
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   req_i, we_i    per-core request and write(1)/read(0) select
//   addr_i         per-core address, core i at [ADDR_W*i +: ADDR_W]
//   wdata_i        per-core write data, core i at [DATA_W*i +: DATA_W]
//   stall_o        per-core stall (req_i & ~done_o), the inverse of the pipe-register enable
//   done_o         registered one-cycle completion pulse for the owner
//   rdata_o        registered last read data, valid while done_o pulses for a read
//   mem_*_o        registered strobe, write enable, address and write data to memory
//   mem_rdata_i    memory read data, RD_LAT cycles after the strobe is sampled
//   dbg_state      current FSM state (IDLE=0, ISSUE=1, RD_WAIT=2, RESP=3)
//
// Handshake: req_i[i] acts as "valid" and is held until done_o[i] pulses.
// done_o[i] acts as a one-cycle "ready". The transfer completes in the cycle
// where both are high. The core must then drop or replace its request at
// the edge that ends that cycle. The arbiter samples req_i only in IDLE, so
// changes to req_i or we_i after the grant have no effect.
module mem_port_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int RD_LAT  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        req_i,
    input  logic [N_CORES-1:0]        we_i,
    input  logic [N_CORES*ADDR_W-1:0] addr_i,
    input  logic [N_CORES*DATA_W-1:0] wdata_i,
    output logic [N_CORES-1:0]        stall_o,
    output logic [N_CORES-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic [1:0]                dbg_state
);

    localparam int PTR_W = $clog2(N_CORES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [2:0]       cnt;

    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] win_next;
    logic [PTR_W:0]   scan_sum;
    logic             found;

    assign stall_o   = req_i & ~done_o;
    assign dbg_state = state;

    // Round-robin search: the first set request bit at or above ptr, wrapping
    // modulo N_CORES. scan_sum has one extra bit so that ptr+k cannot overflow
    // before the wrap.
    always_comb begin
        win      = '0;
        found    = 1'b0;
        scan_sum = '0;
        for (int k = 0; k < N_CORES; k++) begin
            scan_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(N_CORES))
                scan_sum = scan_sum - (PTR_W+1)'(N_CORES);
            if (!found && req_i[scan_sum[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = scan_sum[PTR_W-1:0];
            end
        end
    end

    assign win_next = (win == PTR_W'(N_CORES-1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            done_o      <= '0;
            rdata_o     <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            done_o <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner       <= win;
                        ptr         <= win_next;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= we_i[win];
                        mem_addr_o  <= addr_i[ADDR_W*win +: ADDR_W];
                        mem_wdata_o <= wdata_i[DATA_W*win +: DATA_W];
                        state       <= ISSUE;
                    end else begin
                        mem_en_o <= 1'b0;
                    end
                end
                ISSUE: begin
                    // The memory samples the strobe at this edge. The address
                    // and write data stay on the bus afterwards.
                    mem_en_o <= 1'b0;
                    mem_we_o <= 1'b0;
                    if (mem_we_o) begin
                        done_o <= {{(N_CORES-1){1'b0}}, 1'b1} << owner;
                        state  <= RESP;
                    end else begin
                        cnt   <= 3'd1;
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt == 3'(RD_LAT)) begin
                        rdata_o <= mem_rdata_i;
                        done_o  <= {{(N_CORES-1){1'b0}}, 1'b1} << owner;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (N_CORES=4, ADDR_W=DATA_W=64, RD_LAT=2).
// Inputs are driven 1ns after each rising edge. Outputs are checked later in
// the same cycle.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_i;
    logic [N-1:0]    we_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    stall_o;
    logic [N-1:0]    done_o;
    logic [DW-1:0]   rdata_o;
    logic            mem_en_o;
    logic            mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [DW-1:0]   mem_rdata_i;
    logic [1:0]      dbg_state;

    int total;
    int bad;
    int w;

    mem_port_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .dbg_state  (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input int c, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        we_i[c]            = we;
        addr_i[AW*c +: AW]  = a;
        wdata_i[DW*c +: DW] = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req_i = '0;
        we_i  = '0;
        addr_i = '0;
        wdata_i = '0;
        mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_addr", mem_addr_o, 0);
        reset = 1'b0;
        cyc();

        // write from core 0, ptr 0 -> 1
        req_i = 4'b0001;
        set_core(0, 1'b1, 64'h10, 64'hDEADBEEF);
        #1;
        chk("t1_c0_stall", stall_o, 4'b0001);
        chk("t1_c0_en", mem_en_o, 0);
        cyc();
        chk("t1_c1_en", mem_en_o, 1);
        chk("t1_c1_we", mem_we_o, 1);
        chk("t1_c1_addr", mem_addr_o, 64'h10);
        chk("t1_c1_wdata", mem_wdata_o, 64'hDEADBEEF);
        chk("t1_c1_stall", stall_o, 4'b0001);
        chk("t1_c1_state", dbg_state, 1);
        cyc();
        chk("t1_c2_done", done_o, 4'b0001);
        chk("t1_c2_stall", stall_o, 4'b0000);
        chk("t1_c2_en", mem_en_o, 0);
        chk("t1_c2_addr_hold", mem_addr_o, 64'h10);
        chk("t1_c2_state", dbg_state, 3);
        req_i = '0;
        we_i  = '0;
        cyc();
        chk("t1_c3_done", done_o, 0);
        chk("t1_c3_state", dbg_state, 0);

        // read from core 2, ptr 1 -> 3
        req_i = 4'b0100;
        set_core(2, 1'b0, 64'h20, 64'h0);
        cyc();
        chk("t2_c1_en", mem_en_o, 1);
        chk("t2_c1_we", mem_we_o, 0);
        chk("t2_c1_addr", mem_addr_o, 64'h20);
        cyc();
        chk("t2_c2_en", mem_en_o, 0);
        chk("t2_c2_state", dbg_state, 2);
        chk("t2_c2_stall", stall_o, 4'b0100);
        cyc();
        mem_rdata_i = 64'h1234;
        #1;
        chk("t2_c3_done", done_o, 0);
        chk("t2_c3_state", dbg_state, 2);
        cyc();
        chk("t2_c4_done", done_o, 4'b0100);
        chk("t2_c4_rdata", rdata_o, 64'h1234);
        chk("t2_c4_stall", stall_o, 4'b0000);
        mem_rdata_i = 64'h5555;
        req_i = '0;
        cyc();
        chk("t2_c5_done", done_o, 0);

        // write from core 3 moves ptr to 0 and must not touch rdata_o
        req_i = 4'b1000;
        set_core(3, 1'b1, 64'h30, 64'h33);
        cyc();
        chk("t3_pre_addr", mem_addr_o, 64'h30);
        cyc();
        chk("t3_pre_done", done_o, 4'b1000);
        chk("t3_pre_rdata_hold", rdata_o, 64'h1234);
        req_i = 4'b1111;
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 64'h100 + 64'(i), 64'hA0 + 64'(i));
        cyc();

        // all four request continuously: grants 0,1,2,3,0 with one done every 3 cycles
        for (int t = 0; t < 5; t++) begin
            w = t % N;
            chk("t3_idle_done", done_o, 0);
            chk("t3_idle_state", dbg_state, 0);
            chk("t3_idle_stall", stall_o, 4'b1111);
            cyc();
            chk("t3_issue_en", mem_en_o, 1);
            chk("t3_issue_addr", mem_addr_o, 64'h100 + 64'(w));
            chk("t3_issue_wdata", mem_wdata_o, 64'hA0 + 64'(w));
            cyc();
            chk("t3_resp_done", done_o, 64'(4'b0001 << w));
            chk("t3_resp_stall", stall_o, 64'(4'b1111 & ~(4'b0001 << w)));
            if (t == 4) req_i = 4'b0010;
            cyc();
        end
        chk("t3_rdata_hold", rdata_o, 64'h1234);

        // core 1 write: ptr 1 -> 2
        cyc();
        chk("t4_pre_addr", mem_addr_o, 64'h101);
        cyc();
        chk("t4_pre_done", done_o, 4'b0010);
        req_i = 4'b1010;
        cyc();

        // fairness from ptr 2 with req 1010: core 3 first, then core 1
        chk("t4_idle_stall", stall_o, 4'b1010);
        cyc();
        chk("t4_g3_addr", mem_addr_o, 64'h103);
        chk("t4_g3_stall", stall_o, 4'b1010);
        cyc();
        chk("t4_g3_done", done_o, 4'b1000);
        chk("t4_g3_stall_c1", stall_o, 4'b0010);
        req_i = 4'b0010;
        cyc();
        chk("t4_idle2_stall", stall_o, 4'b0010);
        chk("t4_idle2_done", done_o, 0);
        cyc();
        chk("t4_g1_addr", mem_addr_o, 64'h101);
        chk("t4_g1_stall", stall_o, 4'b0010);
        cyc();
        chk("t4_g1_done", done_o, 4'b0010);
        chk("t4_g1_stall_rel", stall_o, 4'b0000);
        req_i = 4'b0100;
        set_core(2, 1'b1, 64'h202, 64'h22);
        cyc();

        // owner drops its request during ISSUE; ptr 2 -> 3
        cyc();
        chk("t6_issue_en", mem_en_o, 1);
        chk("t6_issue_addr", mem_addr_o, 64'h202);
        req_i = '0;
        #1;
        chk("t6_drop_stall", stall_o, 4'b0000);
        cyc();
        chk("t6_resp_done", done_o, 4'b0100);
        cyc();
        chk("t6_idle_en", mem_en_o, 0);
        chk("t6_idle_state", dbg_state, 0);
        cyc();
        chk("t6_no_reissue_en", mem_en_o, 0);
        chk("t6_no_reissue_state", dbg_state, 0);

        // read from core 0 (ptr 3 wraps to 0), async reset in the middle of RD_WAIT
        req_i = 4'b0001;
        set_core(0, 1'b0, 64'h40, 64'h0);
        cyc();
        chk("t5_issue_addr", mem_addr_o, 64'h40);
        chk("t5_issue_we", mem_we_o, 0);
        cyc();
        chk("t5_rdwait_state", dbg_state, 2);
        mem_rdata_i = 64'hABCD;
        #1;
        reset = 1'b1;
        #1;
        chk("t5_arst_state", dbg_state, 0);
        chk("t5_arst_en", mem_en_o, 0);
        chk("t5_arst_we", mem_we_o, 0);
        chk("t5_arst_addr", mem_addr_o, 0);
        chk("t5_arst_wdata", mem_wdata_o, 0);
        chk("t5_arst_done", done_o, 0);
        chk("t5_arst_rdata", rdata_o, 0);
        chk("t5_arst_stall", stall_o, 4'b0001);
        cyc();
        reset = 1'b0;
        req_i = 4'b0010;
        set_core(1, 1'b0, 64'h50, 64'h0);
        mem_rdata_i = 64'h77;
        #1;
        chk("t5_rel_state", dbg_state, 0);
        chk("t5_rel_en", mem_en_o, 0);
        cyc();
        chk("t5_g1_en", mem_en_o, 1);
        chk("t5_g1_addr", mem_addr_o, 64'h50);
        chk("t5_g1_we", mem_we_o, 0);
        cyc();
        chk("t5_wait1_done", done_o, 0);
        cyc();
        chk("t5_wait2_done", done_o, 0);
        cyc();
        chk("t5_resp_done", done_o, 4'b0010);
        chk("t5_resp_rdata", rdata_o, 64'h77);
        req_i = '0;
        cyc();
        chk("t5_end_done", done_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
